combo_code_ctrl: RTL and testbench
==================================

Name: combo_code_ctrl

Overview:
- Holds the safe's reference combination and supplies the digit selected by `sel` to the digit comparator, in place of hard-wired constants.
- Lets the user program a new NDIG-number combination from the dial, but only while the safe is open.
- Counts failed opening attempts and enforces a timed lockout.
- Runs on the 1 ms system clock next to the master FSM, the BCD counter and the comparator.

Parameters:
- NDIG, 3, number of combination entries (max 4, indexed by 2-bit `sel`)
- DEF_CODE, 24'h15_42_07, reset combination; entry i = DEF_CODE[8i+7:8i], two BCD digits each
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout
- LOCKOUT_MS, 10000, lockout duration in clk cycles (1 ms each)
- PROG_TMO_MS, 15000, programming abort timeout in clk cycles

Ports:
- clk  in  1  1 ms system clock
- rst  in  1  synchronous, active-high reset
- prog  in  1  programming request button, level; edge-detected internally
- safe_open  in  1  from master FSM; door unlocked and open
- dirch  in  1  1-cycle pulse from the dial decoder on direction change
- bcd0  in  4  current dial value, units digit
- bcd1  in  4  current dial value, tens digit
- sel  in  2  comparator entry index from master FSM
- attempt_ok  in  1  1-cycle pulse; full combination matched
- attempt_fail  in  1  1-cycle pulse; attempt rejected
- ref_bcd  out  8  {tens, units} of code entry `sel`; combinational
- prog_active  out  1  programming in progress
- prog_idx  out  2  next entry to capture
- prog_done  out  1  1-cycle pulse; new code committed
- locked_out  out  1  lockout active; master FSM ignores the dial while high
- fail_cnt  out  2  consecutive failures

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: code = DEF_CODE; prog_active = 0; prog_idx = 0; prog_done = 0; locked_out = 0; fail_cnt = 0; state = IDLE; prog edge register = 0; timer = 0.
- ref_bcd: code[sel] when sel < NDIG, otherwise 8'h00. Purely combinational, with no latency.
- States: IDLE, PROG, COMMIT, LOCKOUT.
- IDLE:
  - A rising edge on prog with safe_open = 1 moves to PROG next cycle, with prog_idx = 0 and the timer loaded to PROG_TMO_MS-1.
  - A prog edge with safe_open = 0 is ignored.
  - attempt_ok clears fail_cnt.
  - attempt_fail increments fail_cnt. If the increment reaches MAX_FAIL, go to LOCKOUT, set locked_out = 1 next cycle and load the timer to LOCKOUT_MS-1.
  - If attempt_ok and attempt_fail arrive in the same cycle, treat it as fail.
- PROG:
  - prog_active = 1.
  - On dirch: if both nibbles are ≤ 9, store {bcd1,bcd0} in shadow[prog_idx], increment prog_idx and reload the timer.
  - If either nibble is > 9, abort.
  - After the NDIG-th capture, go to COMMIT.
  - Abort conditions: safe_open falls, a second prog edge, timer expiry, or a non-BCD capture.
  - Abort returns to IDLE with code unchanged, shadow discarded and prog_idx = 0.
  - attempt pulses are ignored in PROG.
- COMMIT: one cycle; code <= shadow; prog_done = 1; fail_cnt = 0; go to IDLE. prog_active stays 1 during COMMIT.
- LOCKOUT:
  - Timer decrements once per clk.
  - When the timer is 0, go to IDLE, with locked_out = 0 and fail_cnt = 0 in the same transition.
  - prog, dirch and attempt pulses are ignored.
  - The total time with locked_out high is exactly LOCKOUT_MS cycles.
- fail_cnt saturates at MAX_FAIL.
- Reset mid-operation (any state) restores DEF_CODE, including after a committed programming. The code is volatile.

Decomposition:
- Shared package safe_pkg:
  - state encoding for IDLE, PROG, COMMIT, LOCKOUT
  - NDIG
  - DEF_CODE
  - timer width constant: ceil(log2(max(LOCKOUT_MS, PROG_TMO_MS)))
- Sub-module ms_downcounter:
  - ports: load, load_val, en, zero
  - one instance is shared by the programming timeout and the lockout, since those states are mutually exclusive.
- Shadow and code registers and the FSM stay in the top of the block.

Test Plan:
1. Program a new code: after reset, ref_bcd with sel = 0, 1, 2 reads 07, 42, 15. Then:
   - set safe_open = 1 and pulse prog
   - dirch at dial values 33, 08, 91
   - expected: prog_done pulses 1 cycle after the third dirch, and sel = 0, 1, 2 then reads 33, 08, 91.
2. Program while closed: prog edge with safe_open = 0 → prog_active stays 0 and the code is unchanged.
3. Abort paths, each from mid-programming with the code unchanged afterwards:
   - safe_open drops after 2 captures → IDLE with prog_idx = 0
   - second prog edge → IDLE
   - no dirch for 15000 cycles → abort at cycle 15000
   - dial value 8'h3A captured → abort
4. Lockout: three attempt_fail pulses → locked_out rises 1 cycle after the third and stays high exactly 10000 cycles; it then falls with fail_cnt = 0.
5. Lockout guards:
   - an attempt_ok between fails resets fail_cnt to 0
   - attempt_ok and attempt_fail in the same cycle count as a fail
   - dirch and prog during lockout are ignored
6. Reset after programming: rst for 1 cycle after a committed code of 33, 08, 91 → ref_bcd returns to 07, 42, 15 and all outputs return to their reset values.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared constants and types for the safe's combination controller.
package safe_pkg;

  // Number of combination entries (at most 4, addressed by a 2-bit index).
  localparam int NDIG = 3;

  // Power-up combination; entry i lives in bits [8i+7:8i] as {tens, units}.
  localparam logic [8*NDIG-1:0] DEF_CODE = 24'h15_42_07;

  // Consecutive failed attempts that trigger a lockout.
  localparam int MAX_FAIL = 3;

  // Lockout length and programming inactivity timeout, in 1 ms clock cycles.
  localparam int LOCKOUT_MS  = 10000;
  localparam int PROG_TMO_MS = 15000;

  // One timer serves both waits, so it is sized for the longer of the two.
  localparam int TMR_W = $clog2((LOCKOUT_MS > PROG_TMO_MS) ? LOCKOUT_MS : PROG_TMO_MS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROG    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // True when the nibble holds a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/ms_downcounter.sv
// Loadable down-counter that stops at zero; flags zero combinationally.
module ms_downcounter
  import safe_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; counting holds once zero is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/combo_code_ctrl.sv
// Reference combination store, dial programming and failed-attempt lockout.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | normal operation; counts failures, waits for a prog press
//   ST_PROG    | capturing new entries from the dial, inactivity timer runs
//   ST_COMMIT  | one cycle: shadow copied into the live code, done pulse
//   ST_LOCKOUT | too many failures; dial ignored until the timer runs out
module combo_code_ctrl
  import safe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       prog,
  input  logic       safe_open,
  input  logic       dirch,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [1:0] sel,
  input  logic       attempt_ok,
  input  logic       attempt_fail,
  output logic [7:0] ref_bcd,
  output logic       prog_active,
  output logic [1:0] prog_idx,
  output logic       prog_done,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  localparam logic [1:0]       FAIL_LIM  = 2'(MAX_FAIL);
  localparam logic [1:0]       LAST_IDX  = 2'(NDIG - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(PROG_TMO_MS - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_MS - 1);

  state_e           state_q, state_d;
  logic             prog_dly_q, prog_dly_d;
  logic [7:0]       code_q   [NDIG];
  logic [7:0]       code_d   [NDIG];
  logic [7:0]       shadow_q [NDIG];
  logic [7:0]       shadow_d [NDIG];
  logic [1:0]       prog_idx_q, prog_idx_d;
  logic [1:0]       fail_cnt_q, fail_cnt_d;

  logic             prog_edge;
  logic             dial_is_bcd;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;

  assign prog_edge   = prog & ~prog_dly_q;
  assign dial_is_bcd = is_bcd(bcd0) && is_bcd(bcd1);

  // Programming timeout and lockout never overlap, so they share one timer.
  assign tmr_en = (state_q == ST_PROG) || (state_q == ST_LOCKOUT);

  ms_downcounter #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Comparator lookup; entries beyond NDIG read as zero.
  always_comb begin
    ref_bcd = 8'h00;
    for (int i = 0; i < NDIG; i++) begin
      if (int'(sel) == i) begin
        ref_bcd = code_q[i];
      end
    end
  end

  // Next-state, failure counting, capture and timer control.
  always_comb begin
    state_d    = state_q;
    prog_dly_d = prog;
    code_d     = code_q;
    shadow_d   = shadow_q;
    prog_idx_d = prog_idx_q;
    fail_cnt_d = fail_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = TMO_LOAD;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous ok and fail is scored as a fail.
        if (attempt_fail) begin
          if (fail_cnt_q >= FAIL_LIM - 2'd1) begin
            fail_cnt_d = FAIL_LIM;
            state_d    = ST_LOCKOUT;
            tmr_load   = 1'b1;
            tmr_val    = LOCK_LOAD;
          end else begin
            fail_cnt_d = fail_cnt_q + 2'd1;
          end
        end else if (attempt_ok) begin
          fail_cnt_d = '0;
        end
        // Entering lockout takes priority over a programming request.
        if ((state_d == ST_IDLE) && prog_edge && safe_open) begin
          state_d    = ST_PROG;
          prog_idx_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = TMO_LOAD;
        end
      end

      ST_PROG: begin
        if (!safe_open || prog_edge || (dirch && !dial_is_bcd)) begin
          state_d    = ST_IDLE;
          prog_idx_d = '0;
        end else if (dirch) begin
          for (int i = 0; i < NDIG; i++) begin
            if (int'(prog_idx_q) == i) begin
              shadow_d[i] = {bcd1, bcd0};
            end
          end
          prog_idx_d = prog_idx_q + 2'd1;
          tmr_load   = 1'b1;
          tmr_val    = TMO_LOAD;
          if (prog_idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end
        end else if (tmr_zero) begin
          state_d    = ST_IDLE;
          prog_idx_d = '0;
        end
      end

      ST_COMMIT: begin
        code_d     = shadow_q;
        fail_cnt_d = '0;
        prog_idx_d = '0;
        state_d    = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, code and shadow registers; the code is volatile across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prog_dly_q <= 1'b0;
      prog_idx_q <= '0;
      fail_cnt_q <= '0;
      for (int i = 0; i < NDIG; i++) begin
        code_q[i]   <= DEF_CODE[8*i +: 8];
        shadow_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      prog_dly_q <= prog_dly_d;
      prog_idx_q <= prog_idx_d;
      fail_cnt_q <= fail_cnt_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
    end
  end

  assign prog_active = (state_q == ST_PROG) || (state_q == ST_COMMIT);
  assign prog_done   = (state_q == ST_COMMIT);
  assign locked_out  = (state_q == ST_LOCKOUT);
  assign prog_idx    = prog_idx_q;
  assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_combo_code_ctrl.sv
// Bench for combo_code_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the safe's rules.
module tb_combo_code_ctrl;
  import safe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog = 1'b0;
  logic       safe_open = 1'b0;
  logic       dirch = 1'b0;
  logic [3:0] bcd0 = 4'd0;
  logic [3:0] bcd1 = 4'd0;
  logic [1:0] sel = 2'd0;
  logic       attempt_ok = 1'b0;
  logic       attempt_fail = 1'b0;
  logic [7:0] ref_bcd;
  logic       prog_active;
  logic [1:0] prog_idx;
  logic       prog_done;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  combo_code_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .prog         (prog),
    .safe_open    (safe_open),
    .dirch        (dirch),
    .bcd0         (bcd0),
    .bcd1         (bcd1),
    .sel          (sel),
    .attempt_ok   (attempt_ok),
    .attempt_fail (attempt_fail),
    .ref_bcd      (ref_bcd),
    .prog_active  (prog_active),
    .prog_idx     (prog_idx),
    .prog_done    (prog_done),
    .locked_out   (locked_out),
    .fail_cnt     (fail_cnt)
  );

  // Behavioural model: live code, failure tally, cycles of lockout left,
  // captured digits so far, idle cycles while programming, pending commit.
  int         m_code [4];
  int         m_fails = 0;
  int         lock_left = 0;
  int         quiet = 0;
  bit         in_prog = 1'b0;
  bit         commit_pend = 1'b0;
  bit         m_prev_prog = 1'b0;
  logic [7:0] cap [$];

  always @(posedge clk) begin : model_step
    bit edge_p;
    edge_p      = prog && !m_prev_prog;
    m_prev_prog = rst ? 1'b0 : prog;
    if (rst) begin
      for (int i = 0; i < 4; i++)
        m_code[i] = (i < NDIG) ? int'(DEF_CODE[8*i +: 8]) : 0;
      m_fails = 0; lock_left = 0; quiet = 0;
      in_prog = 1'b0; commit_pend = 1'b0; cap.delete();
    end else if (commit_pend) begin
      for (int i = 0; i < NDIG; i++) m_code[i] = int'(cap[i]);
      cap.delete(); commit_pend = 1'b0; m_fails = 0;
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) m_fails = 0;
    end else if (in_prog) begin
      if (!safe_open || edge_p || (dirch && (bcd0 > 4'd9 || bcd1 > 4'd9))) begin
        in_prog = 1'b0; cap.delete();
      end else if (dirch) begin
        cap.push_back({bcd1, bcd0});
        quiet = 0;
        if (cap.size() == NDIG) begin
          in_prog = 1'b0; commit_pend = 1'b1;
        end
      end else begin
        quiet++;
        if (quiet == PROG_TMO_MS) begin
          in_prog = 1'b0; cap.delete();
        end
      end
    end else begin
      if (attempt_fail) begin
        m_fails++;
        if (m_fails >= MAX_FAIL) begin
          m_fails = MAX_FAIL; lock_left = LOCKOUT_MS;
        end
      end else if (attempt_ok) begin
        m_fails = 0;
      end
      if (lock_left == 0 && edge_p && safe_open) begin
        in_prog = 1'b1; quiet = 0; cap.delete();
      end
    end
  end

  // Literal expectations posted by the stimulus, checked at the next negedge.
  bit    chk_en = 1'b0;
  int    pin_seq = 0;
  int    pin_seen = 0;
  int    pin_id = 0;
  int    pin_exp = 0;
  int    pin_act = 0;
  string pin_name = "";

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int exp_ref;
    int act;
    if (chk_en) begin
      exp_ref = (int'(sel) < NDIG) ? m_code[sel] : 0;
      vectors++;
      chk("ref_bcd", int'(ref_bcd), exp_ref);
      chk("prog_active", int'(prog_active), int'(in_prog || commit_pend));
      chk("prog_done", int'(prog_done), int'(commit_pend));
      chk("prog_idx", int'(prog_idx), cap.size() % 4);
      chk("locked_out", int'(locked_out), int'(lock_left > 0));
      chk("fail_cnt", int'(fail_cnt), m_fails);
      if (pin_seq != pin_seen) begin
        pin_seen = pin_seq;
        vectors++;
        case (pin_id)
          0:       act = int'(ref_bcd);
          1:       act = int'(prog_active);
          2:       act = int'(prog_idx);
          3:       act = int'(prog_done);
          4:       act = int'(locked_out);
          5:       act = int'(fail_cnt);
          default: act = pin_act;
        endcase
        chk(pin_name, act, pin_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dirch = 1'b0; attempt_ok = 1'b0; attempt_fail = 1'b0;
    sel = 2'($urandom_range(0, 3));
  endtask

  task automatic pin(input string nm, input int id, input int exp, input int act = 0);
    pin_name = nm; pin_id = id; pin_exp = exp; pin_act = act;
    pin_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic check_ref(input logic [1:0] s, input int exp);
    sel = s;
    pin("ref_lit", 0, exp);
  endtask

  task automatic press();
    prog = 1'b1; tick();
    prog = 1'b0; tick();
  endtask

  task automatic dial(input logic [7:0] v);
    {bcd1, bcd0} = v;
    dirch = 1'b1;
    tick();
  endtask

  task automatic pin_reset_outputs();
    pin("rst_prog_active", 1, 0);
    pin("rst_prog_idx", 2, 0);
    pin("rst_prog_done", 3, 0);
    pin("rst_locked_out", 4, 0);
    pin("rst_fail_cnt", 5, 0);
    check_ref(2'd0, 8'h07);
    check_ref(2'd1, 8'h42);
    check_ref(2'd2, 8'h15);
    check_ref(2'd3, 8'h00);
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; tick();
    chk_en = 1'b1; tick();
    rst = 1'b0; tick();
    pin_reset_outputs();

    // New combination 33-08-91 while open.
    safe_open = 1'b1;
    press();
    pin("prog_entered", 1, 1);
    dial(8'h33); tick();
    dial(8'h08);
    dial(8'h91);
    pin("done_pulse", 3, 1);
    tick();
    pin("done_gone", 3, 0);
    check_ref(2'd0, 8'h33);
    check_ref(2'd1, 8'h08);
    check_ref(2'd2, 8'h91);

    // Programming request while the door is closed.
    safe_open = 1'b0;
    press();
    pin("closed_no_prog", 1, 0);

    // Abort: door closes after two captures.
    safe_open = 1'b1;
    press();
    dial(8'h12); dial(8'h34);
    pin("idx_after_two", 2, 2);
    safe_open = 1'b0; tick();
    pin("abort_close", 1, 0);
    pin("abort_close_idx", 2, 0);
    check_ref(2'd1, 8'h08);

    // Abort: second prog press.
    safe_open = 1'b1;
    press();
    dial(8'h11);
    press();
    pin("abort_reprog", 1, 0);

    // Abort: inactivity timeout, measured from entry to fall.
    prog = 1'b1; tick(); prog = 1'b0;
    n = 0;
    while (prog_active && n < 20000) begin tick(); n++; end
    pin("timeout_len", 6, PROG_TMO_MS, n);
    check_ref(2'd2, 8'h91);

    // Abort: non-BCD captures in either digit.
    press(); dial(8'h3A);
    pin("abort_badunits", 1, 0);
    press(); dial(8'h21); dial(8'hA3);
    pin("abort_badtens", 1, 0);
    check_ref(2'd0, 8'h33);

    // Three failures give exactly LOCKOUT_MS cycles of lockout.
    safe_open = 1'b0;
    attempt_fail = 1'b1; tick();
    pin("fail_one", 5, 1);
    attempt_fail = 1'b1; tick();
    pin("fail_two", 5, 2);
    attempt_fail = 1'b1; tick();
    n = 0;
    while (locked_out && n < 20000) begin tick(); n++; end
    pin("lockout_len", 6, LOCKOUT_MS, n);
    pin("lock_released", 4, 0);
    pin("fail_cleared", 5, 0);

    // ok clears the tally; ok+fail together is a fail; inputs ignored when locked.
    attempt_fail = 1'b1; tick();
    attempt_fail = 1'b1; tick();
    attempt_ok = 1'b1; tick();
    pin("ok_clears", 5, 0);
    attempt_fail = 1'b1; tick();
    attempt_ok = 1'b1; attempt_fail = 1'b1; tick();
    pin("both_is_fail", 5, 2);
    attempt_fail = 1'b1; tick();
    safe_open = 1'b1;
    prog = 1'b1; tick(); prog = 1'b0;
    dial(8'h55);
    attempt_ok = 1'b1; tick();
    pin("lock_ignores_prog", 1, 0);
    pin("lock_holds", 4, 1);
    pin("lock_fail_sat", 5, 3);
    n = 0;
    while (locked_out && n < 20000) begin tick(); n++; end
    pin("lock2_released", 4, 0);
    pin("lock2_fail_cleared", 5, 0);

    // Reset after a committed code restores the power-up combination.
    press();
    dial(8'h33); dial(8'h08); dial(8'h91);
    tick();
    check_ref(2'd1, 8'h08);
    rst = 1'b1; tick();
    rst = 1'b0;
    pin_reset_outputs();

    // Random traffic against the model.
    safe_open = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) prog = ~prog;
      if ($urandom_range(0, 59) == 0) safe_open = ~safe_open;
      dirch = ($urandom_range(0, 2) == 0);
      bcd0 = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      bcd1 = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      attempt_ok   = ($urandom_range(0, 29) == 0);
      attempt_fail = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
